// File: rtl/pipe_stage_buf.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_buf
// Purpose  : Elastic pipeline register placed at every inter-stage boundary.
//            It is a DEPTH-entry circular buffer of {ctrl, data} words with a
//            valid/ready handshake on both sides. in_ready comes from
//            registered occupancy only, so back-pressure never forms a
//            combinational path from out_ready to in_ready. flush squashes
//            every held entry, e.g. on a branch mispredict or a trap.
// Ports    : clk, reset (sync, active-high), flush
//            in_valid/in_ready/in_data/in_ctrl     upstream side
//            out_valid/out_ready/out_data/out_ctrl downstream side
//                                                  (zero bubble when empty)
//            count                                 occupancy 0..DEPTH
//            stall_cycles                          PIPE_STAGE_BUF_STATS_EN only
// Options  : `define PIPE_STAGE_BUF_STATS_EN adds the saturating stall_cycles
//            counter output. When undefined the port does not exist.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_buf #(
  parameter  int DATA_WIDTH = 64,
  parameter  int CTRL_WIDTH = 8,
  parameter  int DEPTH      = 2,
  localparam int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic [CNT_W-1:0]      count
`ifdef PIPE_STAGE_BUF_STATS_EN
  ,
  output logic [31:0]           stall_cycles
`endif
);

  // A single-entry buffer still needs a 1-bit pointer so the vectors are legal.
  localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int ENTRY_W = DATA_WIDTH + CTRL_WIDTH;

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [CNT_W-1:0]   count_q;
  logic [ENTRY_W-1:0] head;
  logic               push;
  logic               pop;

  // DEPTH need not be a power of two, so wrap explicitly at DEPTH-1.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    if (ptr == PTR_W'(DEPTH - 1)) begin
      return '0;
    end
    return ptr + 1'b1;
  endfunction

  assign in_ready  = (count_q != CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign count     = count_q;

  assign head     = mem[rd_ptr];
  assign out_data = out_valid ? head[DATA_WIDTH-1:0]       : '0;
  assign out_ctrl = out_valid ? head[ENTRY_W-1:DATA_WIDTH] : '0;

  // Pointer and occupancy state. Reset wins over flush; during a flush the
  // handshakes of that cycle are discarded.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= next_ptr(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage has no reset; contents are only observable through out_valid.
  always_ff @(posedge clk) begin
    if (push && !flush && !reset) begin
      mem[wr_ptr] <= {in_ctrl, in_data};
    end
  end

`ifdef PIPE_STAGE_BUF_STATS_EN
  // Counts cycles in which upstream is blocked by a full buffer. Flush cycles
  // are excluded because the offered word is squashed anyway.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= '0;
    end else if (in_valid && !in_ready && !flush && (stall_cycles != 32'hFFFF_FFFF)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_buf.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_stage_buf
// Purpose  : Self-checking bench for pipe_stage_buf. A DEPTH=2 instance runs
//            a table of directed vectors (handshake, back-pressure, flush,
//            reset-with-flush); a DEPTH=3 instance streams 10 words across
//            pointer wrap; the stall counter is exercised when
//            PIPE_STAGE_BUF_STATS_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_buf;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // DEPTH=2 instance signals
  logic        flush, in_valid, in_ready, out_valid, out_ready;
  logic [63:0] in_data, out_data;
  logic [7:0]  in_ctrl, out_ctrl;
  logic [1:0]  count;
`ifdef PIPE_STAGE_BUF_STATS_EN
  logic [31:0] stall_cycles;
`endif

  // DEPTH=3 instance signals
  logic        d3_flush, d3_in_valid, d3_in_ready, d3_out_valid, d3_out_ready;
  logic [63:0] d3_in_data, d3_out_data;
  logic [7:0]  d3_in_ctrl, d3_out_ctrl;
  logic [1:0]  d3_count;
`ifdef PIPE_STAGE_BUF_STATS_EN
  logic [31:0] d3_stall_cycles;
`endif

  pipe_stage_buf #(.DATA_WIDTH(64), .CTRL_WIDTH(8), .DEPTH(2)) u_dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
    .count(count)
`ifdef PIPE_STAGE_BUF_STATS_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  pipe_stage_buf #(.DATA_WIDTH(64), .CTRL_WIDTH(8), .DEPTH(3)) u_dut3 (
    .clk(clk), .reset(reset), .flush(d3_flush),
    .in_valid(d3_in_valid), .in_ready(d3_in_ready), .in_data(d3_in_data), .in_ctrl(d3_in_ctrl),
    .out_valid(d3_out_valid), .out_ready(d3_out_ready), .out_data(d3_out_data), .out_ctrl(d3_out_ctrl),
    .count(d3_count)
`ifdef PIPE_STAGE_BUF_STATS_EN
    , .stall_cycles(d3_stall_cycles)
`endif
  );

  typedef struct {
    logic        rst;
    logic        fl;
    logic        iv;
    logic [63:0] d;
    logic [7:0]  c;
    logic        ordy;
    logic [1:0]  e_cnt;
    logic        e_valid;
    logic        e_ready;
    logic [63:0] e_data;
    logic [7:0]  e_ctrl;
  } vec_t;

  localparam int NVEC = 23;
  vec_t tbl [NVEC];

  int checks   = 0;
  int failures = 0;

  function automatic vec_t mk(input logic rst, input logic fl, input logic iv,
                              input logic [63:0] d, input logic [7:0] c, input logic ordy,
                              input logic [1:0] e_cnt, input logic e_valid, input logic e_ready,
                              input logic [63:0] e_data, input logic [7:0] e_ctrl);
    vec_t v;
    v.rst = rst; v.fl = fl; v.iv = iv; v.d = d; v.c = c; v.ordy = ordy;
    v.e_cnt = e_cnt; v.e_valid = e_valid; v.e_ready = e_ready;
    v.e_data = e_data; v.e_ctrl = e_ctrl;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Each row: inputs for this cycle, and outputs expected during this cycle
    // (i.e. state before the edge that applies the row's inputs).
    //             rst fl iv data    ctrl  ordy | cnt vld rdy data    ctrl
    tbl[0]  = mk(0, 0, 0, 64'h0,  8'h0, 1,  2'd0, 0, 1, 64'h0,  8'h0);  // reset state
    tbl[1]  = mk(0, 0, 1, 64'hA1, 8'h5, 1,  2'd0, 0, 1, 64'h0,  8'h0);  // push A1, no bypass
    tbl[2]  = mk(0, 0, 0, 64'h0,  8'h0, 1,  2'd1, 1, 1, 64'hA1, 8'h5);  // A1 visible, consumed
    tbl[3]  = mk(0, 0, 1, 64'h11, 8'h1, 0,  2'd0, 0, 1, 64'h0,  8'h0);  // push 11, stalled
    tbl[4]  = mk(0, 0, 1, 64'h22, 8'h2, 0,  2'd1, 1, 1, 64'h11, 8'h1);  // push 22
    tbl[5]  = mk(0, 0, 1, 64'h33, 8'h3, 0,  2'd2, 1, 0, 64'h11, 8'h1);  // full, 33 refused
    tbl[6]  = mk(0, 0, 1, 64'h33, 8'h3, 1,  2'd2, 1, 0, 64'h11, 8'h1);  // pop 11, 33 still refused
    tbl[7]  = mk(0, 0, 1, 64'h33, 8'h3, 1,  2'd1, 1, 1, 64'h22, 8'h2);  // pop 22 + push 33
    tbl[8]  = mk(0, 0, 0, 64'h0,  8'h0, 1,  2'd1, 1, 1, 64'h33, 8'h3);  // pop 33
    tbl[9]  = mk(0, 0, 0, 64'h0,  8'h0, 1,  2'd0, 0, 1, 64'h0,  8'h0);  // empty bubble
    tbl[10] = mk(0, 0, 1, 64'h55, 8'h5, 0,  2'd0, 0, 1, 64'h0,  8'h0);
    tbl[11] = mk(0, 0, 1, 64'h66, 8'h6, 0,  2'd1, 1, 1, 64'h55, 8'h5);
    tbl[12] = mk(0, 1, 1, 64'h44, 8'h4, 1,  2'd2, 1, 0, 64'h55, 8'h5);  // flush shows pre-flush head
    tbl[13] = mk(0, 0, 0, 64'h0,  8'h0, 1,  2'd0, 0, 1, 64'h0,  8'h0);  // 44 dropped
    tbl[14] = mk(0, 0, 1, 64'h77, 8'h7, 0,  2'd0, 0, 1, 64'h0,  8'h0);
    tbl[15] = mk(0, 0, 1, 64'h88, 8'h8, 0,  2'd1, 1, 1, 64'h77, 8'h7);
    tbl[16] = mk(1, 1, 1, 64'h99, 8'h9, 1,  2'd2, 1, 0, 64'h77, 8'h7);  // reset + flush
    tbl[17] = mk(0, 0, 0, 64'h0,  8'h0, 1,  2'd0, 0, 1, 64'h0,  8'h0);
    tbl[18] = mk(0, 0, 1, 64'hAA, 8'hA, 0,  2'd0, 0, 1, 64'h0,  8'h0);
    tbl[19] = mk(0, 1, 0, 64'h0,  8'h0, 1,  2'd1, 1, 1, 64'hAA, 8'hA);  // flush + pop at count 1
    tbl[20] = mk(0, 0, 1, 64'hBB, 8'hB, 1,  2'd0, 0, 1, 64'h0,  8'h0);
    tbl[21] = mk(0, 0, 0, 64'h0,  8'h0, 1,  2'd1, 1, 1, 64'hBB, 8'hB);
    tbl[22] = mk(0, 0, 0, 64'h0,  8'h0, 1,  2'd0, 0, 1, 64'h0,  8'h0);

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_ctrl = '0; out_ready = 1'b0;
    d3_flush = 1'b0; d3_in_valid = 1'b0; d3_in_data = '0; d3_in_ctrl = '0; d3_out_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // ---------------- table-driven DEPTH=2 vectors ----------------
    for (int i = 0; i < NVEC; i++) begin
      reset     = tbl[i].rst;
      flush     = tbl[i].fl;
      in_valid  = tbl[i].iv;
      in_data   = tbl[i].d;
      in_ctrl   = tbl[i].c;
      out_ready = tbl[i].ordy;
      #1;
      checks++;
      if ({count, out_valid, in_ready, out_data, out_ctrl} !==
          {tbl[i].e_cnt, tbl[i].e_valid, tbl[i].e_ready, tbl[i].e_data, tbl[i].e_ctrl}) begin
        failures++;
        $display("FAIL vec%0d: got cnt=%0d vld=%b rdy=%b data=%h ctrl=%h, want cnt=%0d vld=%b rdy=%b data=%h ctrl=%h",
                 i, count, out_valid, in_ready, out_data, out_ctrl,
                 tbl[i].e_cnt, tbl[i].e_valid, tbl[i].e_ready, tbl[i].e_data, tbl[i].e_ctrl);
      end
      tick();
    end
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;

    // ---------------- DEPTH=3 streaming across pointer wrap ----------------
    d3_out_ready = 1'b1;
    d3_in_valid  = 1'b1;
    d3_in_data   = 64'd1;
    d3_in_ctrl   = 8'd1;
    tick();
    for (int k = 2; k <= 11; k++) begin
      if (k <= 10) begin
        d3_in_valid = 1'b1;
        d3_in_data  = 64'(k);
        d3_in_ctrl  = 8'(k);
      end else begin
        d3_in_valid = 1'b0;
      end
      #1;
      checks++;
      if (d3_out_valid !== 1'b1 || d3_out_data !== 64'(k - 1) ||
          d3_out_ctrl !== 8'(k - 1) || d3_count !== 2'd1) begin
        failures++;
        $display("FAIL stream%0d: got vld=%b data=%0d ctrl=%0d cnt=%0d, want vld=1 data=%0d ctrl=%0d cnt=1",
                 k - 1, d3_out_valid, d3_out_data, d3_out_ctrl, d3_count, k - 1, k - 1);
      end
      tick();
    end
    #1;
    checks++;
    if (d3_out_valid !== 1'b0 || d3_count !== 2'd0 || d3_out_data !== 64'd0) begin
      failures++;
      $display("FAIL stream_drain: got vld=%b cnt=%0d data=%h, want vld=0 cnt=0 data=0",
               d3_out_valid, d3_count, d3_out_data);
    end
    d3_out_ready = 1'b0;

`ifdef PIPE_STAGE_BUF_STATS_EN
    // ---------------- stall counter ----------------
    reset = 1'b1;
    tick();
    reset = 1'b0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 64'hC0;
    in_ctrl   = 8'h1;
    tick();
    tick();                                  // buffer now full
    repeat (5) tick();                       // five blocked cycles
    checks++;
    if (stall_cycles !== 32'd5) begin
      failures++;
      $display("FAIL stall_count: got %0d, want 5", stall_cycles);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (stall_cycles !== 32'd5) begin
      failures++;
      $display("FAIL stall_after_flush: got %0d, want 5", stall_cycles);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (stall_cycles !== 32'd0) begin
      failures++;
      $display("FAIL stall_after_reset: got %0d, want 0", stall_cycles);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
